dmem_timer_responder: RTL and testbench



---
 rtl/dmem_timer_responder_pkg.sv | 42 ++++
 rtl/dmem_timer_responder_prescaler.sv | 30 +++
 rtl/dmem_timer_responder.sv | 137 +++++++++++++
 tb/tb_dmem_timer_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_timer_responder_pkg.sv
// Shared definitions for the memory-mapped machine timer: register word offsets,
// CTRL bit positions, DMEM-side decode base and the address-to-register decoder.
package dmem_timer_responder_pkg;

  localparam logic [31:0] TIMER_MTIME_LO    = 32'h0000_0000;
  localparam logic [31:0] TIMER_MTIME_HI    = 32'h0000_0001;
  localparam logic [31:0] TIMER_MTIMECMP_LO = 32'h0000_0002;
  localparam logic [31:0] TIMER_MTIMECMP_HI = 32'h0000_0003;
  localparam logic [31:0] TIMER_CTRL        = 32'h0000_0004;
  localparam logic [31:0] TIMER_STATUS      = 32'h0000_0005;

  localparam int CTRL_EN_BIT         = 0;
  localparam int CTRL_IRQ_EN_BIT     = 1;
  localparam int CTRL_AUTORELOAD_BIT = 2;
  localparam int CTRL_PRESCALE_LSB   = 8;

  // Byte address at which the data-memory decoder routes accesses to this block.
  localparam logic [31:0] TIMER_DMEM_BASE = 32'h0000_4000;

  typedef enum logic [2:0] {
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_CTRL,
    SEL_STATUS,
    SEL_NONE
  } timer_sel_e;

  function automatic timer_sel_e decode_word(input logic [31:0] word_addr);
    case (word_addr)
      TIMER_MTIME_LO:    return SEL_MTIME_LO;
      TIMER_MTIME_HI:    return SEL_MTIME_HI;
      TIMER_MTIMECMP_LO: return SEL_CMP_LO;
      TIMER_MTIMECMP_HI: return SEL_CMP_HI;
      TIMER_CTRL:        return SEL_CTRL;
      TIMER_STATUS:      return SEL_STATUS;
      default:           return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_timer_responder_prescaler.sv
// Prescale counter for the machine timer: runs 0..prescale while enabled and
// flags a tick on the terminal count; cleared by any CTRL write.
module dmem_timer_responder_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  assign tick = en & (count == prescale);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/dmem_timer_responder.sv
// Machine-timer peripheral on the data-memory port (ceb/web/A/mask/D/Q).
// Optional periodic mode is compiled in with `define TIMER_AUTORELOAD_EN.
module dmem_timer_responder
  import dmem_timer_responder_pkg::*;
#(
  parameter int          PRESCALE_W = 8,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ceb,
  input  logic              web,
  input  logic [ADDR_W-1:0] A,
  input  logic [3:0]        mask,
  input  logic [31:0]       D,
  output logic [31:0]       Q,
  output logic              irq_o
);

  localparam logic [31:0] CTRL_PRESCALE_MASK =
    ((32'd1 << PRESCALE_W) - 32'd1) << CTRL_PRESCALE_LSB;
`ifdef TIMER_AUTORELOAD_EN
  localparam logic [31:0] CTRL_AR_MASK = 32'd1 << CTRL_AUTORELOAD_BIT;
`else
  localparam logic [31:0] CTRL_AR_MASK = 32'd0;
`endif
  localparam logic [31:0] CTRL_WMASK = CTRL_PRESCALE_MASK | CTRL_AR_MASK |
    (32'd1 << CTRL_EN_BIT) | (32'd1 << CTRL_IRQ_EN_BIT);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] ctrl;
  logic [63:0] mtime_inc;
  logic [31:0] rdata;
  timer_sel_e  sel;
  logic        rd, wr;
  logic        wr_lo, wr_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
  logic        tick, reload, time_ge;

  assign sel       = decode_word(32'(A));
  assign rd        = ~ceb & web;
  // An all-zero mask is a no-op: it neither writes nor blocks the increment.
  assign wr        = ~ceb & ~web & (|mask);
  assign wr_lo     = wr & (sel == SEL_MTIME_LO);
  assign wr_hi     = wr & (sel == SEL_MTIME_HI);
  assign wr_cmp_lo = wr & (sel == SEL_CMP_LO);
  assign wr_cmp_hi = wr & (sel == SEL_CMP_HI);
  assign wr_ctrl   = wr & (sel == SEL_CTRL);

  assign mtime_inc = mtime + 64'd1;
  assign time_ge   = (mtime >= mtimecmp);
  assign reload    = tick & ctrl[CTRL_AUTORELOAD_BIT] & (mtime_inc >= mtimecmp);

  dmem_timer_responder_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .resetn   (resetn),
    .en       (ctrl[CTRL_EN_BIT]),
    .clr      (wr_ctrl),
    .prescale (ctrl[CTRL_PRESCALE_LSB +: PRESCALE_W]),
    .tick     (tick)
  );

  // A software write to either half takes precedence over the tick for all 64 bits.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mtime <= '0;
    end else if (wr_lo | wr_hi) begin
      if (wr_lo) mtime[31:0]  <= merge_bytes(mtime[31:0], D, mask);
      if (wr_hi) mtime[63:32] <= merge_bytes(mtime[63:32], D, mask);
    end else if (tick) begin
      mtime <= reload ? 64'd0 : mtime_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mtimecmp <= CMP_RESET;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], D, mask);
      if (wr_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], D, mask);
    end
  end

  // Unimplemented CTRL bits are masked off so they always read back as zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl <= merge_bytes(ctrl, D, mask) & CTRL_WMASK;
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_MTIME_LO: rdata = mtime[31:0];
      SEL_MTIME_HI: rdata = mtime[63:32];
      SEL_CMP_LO:   rdata = mtimecmp[31:0];
      SEL_CMP_HI:   rdata = mtimecmp[63:32];
      SEL_CTRL:     rdata = ctrl;
      SEL_STATUS:   rdata = {31'd0, time_ge};
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      Q <= '0;
    end else if (rd) begin
      Q <= rdata;
    end
  end

  // In periodic mode mtime never reaches mtimecmp, so the wrap itself raises the pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= ctrl[CTRL_IRQ_EN_BIT] & (time_ge | reload);
    end
  end

endmodule

// File: tb/tb_dmem_timer_responder.sv
// Self-checking bench for dmem_timer_responder: directed vector table, hand-written
// timing sequences and randomized traffic against a behavioural timer model.
module tb_dmem_timer_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ceb, web;
  logic [9:0]  A;
  logic [3:0]  mask;
  logic [31:0] D;
  logic [31:0] Q;
  logic        irq_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_timer_responder dut (
    .clk    (clk),
    .resetn (resetn),
    .ceb    (ceb),
    .web    (web),
    .A      (A),
    .mask   (mask),
    .D      (D),
    .Q      (Q),
    .irq_o  (irq_o)
  );

  // Reference model state: plain integers describing the programmer-visible timer.
  logic [63:0] m_time, m_cmp;
  bit          m_en, m_irq_en, m_ar;
  int unsigned m_pre, m_phase;
  logic [31:0] m_q;
  bit          m_irq;

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_ctrl_word();
    return (m_pre << 8) | (32'(m_ar) << 2) | (32'(m_irq_en) << 1) | 32'(m_en);
  endfunction

  function automatic logic [31:0] m_read(input logic [9:0] a);
    case (a)
      10'h000: return m_time[31:0];
      10'h001: return m_time[63:32];
      10'h002: return m_cmp[31:0];
      10'h003: return m_cmp[63:32];
      10'h004: return m_ctrl_word();
      10'h005: return (m_time >= m_cmp) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input bit rn, input bit c, input bit w, input logic [9:0] a,
                            input logic [3:0] m, input logic [31:0] d);
    bit          is_wr, is_rd, ticked, wrapped;
    logic [63:0] nxt;
    logic [31:0] cw;
    if (!rn) begin
      m_time = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_en = 0; m_irq_en = 0; m_ar = 0;
      m_pre = 0; m_phase = 0; m_q = 0; m_irq = 0;
      return;
    end
    is_wr   = !c && !w && (m != 0);
    is_rd   = !c && w;
    ticked  = m_en && (m_phase == m_pre);
    wrapped = ticked && m_ar && (m_time + 64'd1 >= m_cmp);
    nxt     = m_time;
    if (ticked) nxt = wrapped ? 64'd0 : m_time + 64'd1;
    m_irq = m_irq_en && ((m_time >= m_cmp) || wrapped);
    if (is_rd) m_q = m_read(a);
    if (m_en) m_phase = ticked ? 0 : m_phase + 1;
    if (is_wr) begin
      case (a)
        10'h000: nxt = {m_time[63:32], m_merge(m_time[31:0], d, m)};
        10'h001: nxt = {m_merge(m_time[63:32], d, m), m_time[31:0]};
        10'h002: m_cmp[31:0]  = m_merge(m_cmp[31:0], d, m);
        10'h003: m_cmp[63:32] = m_merge(m_cmp[63:32], d, m);
        10'h004: begin
          cw = m_merge(m_ctrl_word(), d, m);
          m_en = cw[0]; m_irq_en = cw[1];
`ifdef TIMER_AUTORELOAD_EN
          m_ar = cw[2];
`endif
          m_pre = cw[15:8]; m_phase = 0;
        end
        default: ;
      endcase
    end
    m_time = nxt;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step(input bit c, input bit w, input logic [9:0] a,
                      input logic [3:0] m, input logic [31:0] d);
    ceb = c; web = w; A = a; mask = m; D = d;
    @(posedge clk);
    model_step(resetn, c, w, a, m, d);
    #1;
    check("model_q", Q, m_q);
    check("model_irq", irq_o, m_irq);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    step(1'b0, 1'b0, a, 4'hF, d);
  endtask

  task automatic rd(input logic [9:0] a);
    step(1'b0, 1'b1, a, 4'h0, 32'h0);
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 10'h0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle();
    resetn = 1'b1;
  endtask

  typedef struct {
    bit          c;
    bit          w;
    logic [9:0]  a;
    logic [3:0]  m;
    logic [31:0] d;
    logic [31:0] q;
    bit          irq;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int pulses;
    logic [9:0]  ra;
    logic [31:0] rdv;
    vecs[0]  = '{1'b0, 1'b1, 10'h002, 4'h0, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 10'h003, 4'h0, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 10'h3FF, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[3]  = '{1'b0, 1'b0, 10'h000, 4'hF, 32'h1234_5678, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 1'b1, 10'h000, 4'h0, 32'h0,         32'h1234_5678, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 10'h000, 4'h2, 32'h0000_AB00, 32'h1234_5678, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 10'h000, 4'h0, 32'h0,         32'h1234_AB78, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 10'h005, 4'hF, 32'hFFFF_FFFF, 32'h1234_AB78, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 10'h005, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[9]  = '{1'b0, 1'b0, 10'h003, 4'hF, 32'h0,         32'h0,         1'b0};
    vecs[10] = '{1'b0, 1'b1, 10'h005, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[11] = '{1'b0, 1'b0, 10'h002, 4'hF, 32'h10,        32'h0,         1'b0};
    vecs[12] = '{1'b0, 1'b1, 10'h005, 4'h0, 32'h0,         32'h1,         1'b0};
    vecs[13] = '{1'b0, 1'b0, 10'h004, 4'hF, 32'h2,         32'h1,         1'b0};
    vecs[14] = '{1'b0, 1'b1, 10'h004, 4'h0, 32'h0,         32'h2,         1'b1};
    vecs[15] = '{1'b0, 1'b0, 10'h004, 4'h2, 32'hFFFF_FF00, 32'h2,         1'b1};
    vecs[16] = '{1'b0, 1'b1, 10'h004, 4'h0, 32'h0,         32'h0000_FF02, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 10'h002, 4'hF, 32'hFFFF_FFFF, 32'h0000_FF02, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 10'h002, 4'h0, 32'h0,         32'hFFFF_FFFF, 1'b0};

    resetn = 1'b0; ceb = 1'b1; web = 1'b1; A = '0; mask = '0; D = '0;
    idle();
    resetn = 1'b1;
    check("reset_q", Q, 32'h0);
    check("reset_irq", irq_o, 1'b0);

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].c, vecs[i].w, vecs[i].a, vecs[i].m, vecs[i].d);
      check($sformatf("vec%0d_q", i), Q, vecs[i].q);
      check($sformatf("vec%0d_irq", i), irq_o, vecs[i].irq);
    end

    // Free-running count with PRESCALE=0.
    do_reset();
    wr(10'h004, 32'h1);
    repeat (10) idle();
    rd(10'h000);
    check("count_in_range", (Q >= 9 && Q <= 11), 1'b1);
    check("count_exact", Q, 32'd10);

    // Carry from MTIME_LO into MTIME_HI.
    do_reset();
    wr(10'h000, 32'hFFFF_FFFE);
    wr(10'h001, 32'h0);
    wr(10'h004, 32'h1);
    idle();
    wr(10'h004, 32'h0);
    rd(10'h001);
    check("carry_hi", Q, 32'h1);
    rd(10'h000);
    check("carry_lo", Q, 32'h0);

    // Interrupt timing against mtimecmp=20.
    do_reset();
    wr(10'h003, 32'h0);
    wr(10'h002, 32'd20);
    wr(10'h004, 32'h3);
    repeat (20) idle();
    check("irq_before", irq_o, 1'b0);
    idle();
    check("irq_rise", irq_o, 1'b1);
    wr(10'h002, 32'hFFFF_FFFF);
    check("irq_hold", irq_o, 1'b1);
    idle();
    check("irq_fall", irq_o, 1'b0);

    // PRESCALE=3 and a byte write colliding with a tick.
    do_reset();
    wr(10'h004, 32'h0000_0301);
    repeat (8) idle();
    rd(10'h000);
    check("prescale_count", Q, 32'd2);
    idle();
    idle();
    step(1'b0, 1'b0, 10'h000, 4'h1, 32'h0000_00AB);
    rd(10'h000);
    check("collision_lo", Q, 32'h0000_00AB);

    // Reset wins over a read in the same cycle.
    rd(10'h000);
    resetn = 1'b0;
    rd(10'h000);
    resetn = 1'b1;
    check("midreset_q", Q, 32'h0);

`ifdef TIMER_AUTORELOAD_EN
    do_reset();
    wr(10'h003, 32'h0);
    wr(10'h002, 32'd5);
    wr(10'h004, 32'h7);
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      rd(10'h000);
      check($sformatf("reload_seq%0d", k), Q, 32'((k - 1) % 5));
      if (irq_o) pulses++;
    end
    check("reload_pulses", pulses, 2);
`else
    pulses = 0;
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      ra = ($urandom_range(0, 9) < 7) ? 10'($urandom_range(0, 5)) : 10'($urandom);
      case (ra)
        10'h002: rdv = $urandom_range(0, 60);
        10'h003: rdv = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
        10'h004: rdv = $urandom & 32'h0000_0307;
        10'h000: rdv = $urandom_range(0, 40);
        default: rdv = $urandom;
      endcase
      resetn = ($urandom_range(0, 199) != 0);
      step(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, ra,
           4'($urandom), rdv);
      resetn = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
